// File: rtl/fpro_mailbox_core.sv
// FPro MMIO slot core with two mailboxes: TX (CPU writes, fabric stream out)
// and RX (fabric stream in, CPU reads/pops). Both share one FIFO primitive.

module fpro_mailbox_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [W-1:0]          din_i,
    output logic [W-1:0]          head_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [W-1:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rp_q];

    // Flush wins over anything else aimed at this FIFO in the same cycle.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wp_d = wp_q + 1'b1;
        if (do_pop)  rp_d = rp_q + 1'b1;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end
endmodule

module fpro_mailbox_core #(
    parameter int DEPTH_LOG2 = 4,
    parameter int W          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready
);
    localparam logic [4:0] A_STATUS  = 5'd0;
    localparam logic [4:0] A_RX_DATA = 5'd1;
    localparam logic [4:0] A_TX_DATA = 5'd2;
    localparam logic [4:0] A_RX_POP  = 5'd3;
    localparam logic [4:0] A_CTRL    = 5'd4;

    logic [W-1:0]        tx_head, rx_head;
    logic [DEPTH_LOG2:0] tx_cnt, rx_cnt;
    logic                tx_full, tx_empty, rx_full, rx_empty;
    logic                wr_tx, wr_pop, wr_ctrl;
    logic                tx_flush, rx_flush, drop_clr, drop_ev;
    logic                tx_drop_q, tx_drop_d;
    logic [4:0]          tx_cnt5, rx_cnt5;

    assign wr_tx   = cs & write & (addr == A_TX_DATA);
    assign wr_pop  = cs & write & (addr == A_RX_POP);
    assign wr_ctrl = cs & write & (addr == A_CTRL);

    assign tx_flush = wr_ctrl & wr_data[0];
    assign rx_flush = wr_ctrl & wr_data[1];
    assign drop_clr = wr_ctrl & wr_data[2];

    // Full is judged on the registered count, so a same-cycle out pop
    // does not rescue a push into a full TX FIFO.
    assign drop_ev   = wr_tx & tx_full & ~tx_flush;
    assign tx_drop_d = drop_ev | (tx_drop_q & ~drop_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx_drop_q <= 1'b0;
        else       tx_drop_q <= tx_drop_d;
    end

    fpro_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(W)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_tx),
        .pop_i   (out_valid & out_ready),
        .flush_i (tx_flush),
        .din_i   (wr_data[W-1:0]),
        .head_o  (tx_head),
        .count_o (tx_cnt),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    fpro_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(W)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid & in_ready),
        .pop_i   (wr_pop),
        .flush_i (rx_flush),
        .din_i   (in_data),
        .head_o  (rx_head),
        .count_o (rx_cnt),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign out_valid = ~tx_empty;
    assign out_data  = tx_empty ? '0 : tx_head;
    assign in_ready  = ~rx_full;

    assign tx_cnt5 = 5'(tx_cnt);
    assign rx_cnt5 = 5'(rx_cnt);

    always_comb begin
        rd_data = '0;
        if (cs & read) begin
            case (addr)
                A_STATUS:  rd_data = {7'b0, tx_drop_q, 3'b0, rx_cnt5, 3'b0, tx_cnt5,
                                      4'b0, rx_empty, rx_full, tx_empty, tx_full};
                A_RX_DATA: rd_data = rx_empty ? 32'h0 : 32'(rx_head);
                default:   rd_data = '0;
            endcase
        end
    end
endmodule
